// File: rtl/digit_crossing_classifier.sv
// Probe-line crossing counter and 0-9 digit classifier for the TFT video path.
// Optional DIGIT_ASPECT_EN: boxes narrower than a quarter of their height classify as digit 1.
module digit_crossing_classifier #(
    parameter int unsigned CW           = 12,
    parameter int unsigned CNT_W        = 4,
    parameter int unsigned FRAME_PERIOD = 4,
    parameter int unsigned FRAME_SEL    = 3,
    parameter int unsigned V1_NUM       = 2,
    parameter int unsigned V2_NUM       = 3,
    parameter int unsigned V_DEN        = 5,
    parameter int unsigned H_NUM        = 1,
    parameter int unsigned H_DEN        = 2
) (
    input  logic             tft_vclk,
    input  logic             rst,
    input  logic             tft_vs,
    input  logic             th_flag,
    input  logic [CW-1:0]    hcount,
    input  logic [CW-1:0]    vcount,
    input  logic [CW-1:0]    box_left,
    input  logic [CW-1:0]    box_right,
    input  logic [CW-1:0]    box_top,
    input  logic [CW-1:0]    box_bottom,
    input  logic             box_valid,
    output logic [CNT_W-1:0] x1,
    output logic [CNT_W-1:0] x2,
    output logic [CNT_W-1:0] y,
    output logic             x1_l,
    output logic             x1_r,
    output logic             x2_l,
    output logic             x2_r,
    output logic [3:0]       digit,
    output logic             digit_valid,
    output logic             busy
);
    localparam int unsigned FW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam int unsigned PW = CW + 8;
    localparam logic [CNT_W-1:0] K1 = CNT_W'(1);
    localparam logic [CNT_W-1:0] K2 = CNT_W'(2);
    localparam logic [CNT_W-1:0] K3 = CNT_W'(3);

    typedef enum logic [2:0] {StIdle, StLatch1, StLatch2, StScan, StClassify} state_t;
    state_t state_q, state_d;

    logic             vs_q, vs_rise, start;
    logic [FW-1:0]    fcnt_q, fcnt_nxt;
    logic [CW-1:0]    left_q, right_q, top_q, bottom_q;
    logic [PW-1:0]    pv1_q, pv2_q, ph_q;
    logic [CW-1:0]    row1_q, row2_q, colp_q;
    logic [CNT_W-1:0] c1_q, c2_q, cy_q;
    logic             l1_q, r1_q, l2_q, r2_q;
    logic             hprev_q, vprev_q;
    logic             in_row, on_r1, on_r2, on_col, h_rise, v_rise;
`ifdef DIGIT_ASPECT_EN
    logic             thin_q;
`endif

    assign vs_rise  = tft_vs & ~vs_q;
    assign fcnt_nxt = (fcnt_q == FW'(FRAME_PERIOD - 1)) ? '0 : fcnt_q + 1'b1;
    assign start    = vs_rise && (fcnt_nxt == FW'(FRAME_SEL)) && box_valid &&
                      (box_right > box_left) && (box_bottom > box_top);
    assign busy     = (state_q != StIdle);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // 2, 3 and 5 share counts and are told apart by which side of the column probe is lit
    function automatic logic [3:0] lookup(input logic [CNT_W-1:0] cy, input logic [CNT_W-1:0] c1,
                                          input logic [CNT_W-1:0] c2, input logic l1,
                                          input logic r1, input logic l2, input logic r2);
        logic [3:0] d;
        d = 4'hF;
        if      (cy == K2 && c1 == K2 && c2 == K2)             d = 4'd0;
        else if (cy == K1 && c1 == K1 && c2 == K1)             d = 4'd1;
        else if (cy == K3 && c1 == K1 && c2 == K1 && r1 && l2) d = 4'd2;
        else if (cy == K3 && c1 == K1 && c2 == K1 && r1 && r2) d = 4'd3;
        else if (cy == K2 && c1 == K2 && c2 == K1)             d = 4'd4;
        else if (cy == K3 && c1 == K1 && c2 == K1 && l1 && r2) d = 4'd5;
        else if (cy == K3 && c1 == K1 && c2 == K2)             d = 4'd6;
        else if (cy == K2 && c1 == K1 && c2 == K1)             d = 4'd7;
        else if (cy == K3 && c1 == K2 && c2 == K2)             d = 4'd8;
        else if (cy == K3 && c1 == K2 && c2 == K1)             d = 4'd9;
        return d;
    endfunction

    always_comb begin
        in_row = (hcount >= left_q) && (hcount <= right_q);
        on_r1  = in_row && (vcount == row1_q);
        on_r2  = in_row && (vcount == row2_q);
        on_col = (hcount == colp_q) && (vcount >= top_q) && (vcount <= bottom_q);
        // box edges act as background so foreground touching an edge still counts
        h_rise = th_flag && ((hcount == left_q) || !hprev_q);
        v_rise = th_flag && ((vcount == top_q) || !vprev_q);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (start) state_d = StLatch1;
            StLatch1:   state_d = StLatch2;
            StLatch2:   state_d = StScan;
            StScan:     if (vs_rise) state_d = StClassify;
            StClassify: state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge tft_vclk) begin
        if (rst) begin
            state_q <= StIdle;
            vs_q    <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            vs_q    <= tft_vs;
            if (vs_rise) fcnt_q <= fcnt_nxt;
        end
    end

    always_ff @(posedge tft_vclk) begin
        if (rst) begin
            left_q <= '0; right_q <= '0; top_q <= '0; bottom_q <= '0;
            pv1_q <= '0; pv2_q <= '0; ph_q <= '0;
            row1_q <= '0; row2_q <= '0; colp_q <= '0;
            c1_q <= '0; c2_q <= '0; cy_q <= '0;
            l1_q <= 1'b0; r1_q <= 1'b0; l2_q <= 1'b0; r2_q <= 1'b0;
            hprev_q <= 1'b0; vprev_q <= 1'b0;
            x1 <= '0; x2 <= '0; y <= '0;
            x1_l <= 1'b0; x1_r <= 1'b0; x2_l <= 1'b0; x2_r <= 1'b0;
            digit <= 4'hF;
            digit_valid <= 1'b0;
`ifdef DIGIT_ASPECT_EN
            thin_q <= 1'b0;
`endif
        end else begin
            digit_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        left_q   <= box_left;
                        right_q  <= box_right;
                        top_q    <= box_top;
                        bottom_q <= box_bottom;
                    end
                end
                StLatch1: begin
                    pv1_q <= PW'(bottom_q - top_q) * PW'(V1_NUM);
                    pv2_q <= PW'(bottom_q - top_q) * PW'(V2_NUM);
                    ph_q  <= PW'(right_q - left_q) * PW'(H_NUM);
`ifdef DIGIT_ASPECT_EN
                    thin_q <= (PW'(right_q - left_q) * PW'(4)) < PW'(bottom_q - top_q);
`endif
                end
                StLatch2: begin
                    row1_q  <= top_q + CW'(pv1_q / PW'(V_DEN));
                    row2_q  <= top_q + CW'(pv2_q / PW'(V_DEN));
                    colp_q  <= left_q + CW'(ph_q / PW'(H_DEN));
                    c1_q <= '0; c2_q <= '0; cy_q <= '0;
                    l1_q <= 1'b0; r1_q <= 1'b0; l2_q <= 1'b0; r2_q <= 1'b0;
                    hprev_q <= 1'b0; vprev_q <= 1'b0;
                end
                StScan: begin
                    if (on_r1) begin
                        if (h_rise) c1_q <= sat_inc(c1_q);
                        if (th_flag && hcount < colp_q) l1_q <= 1'b1;
                        if (th_flag && hcount > colp_q) r1_q <= 1'b1;
                    end
                    if (on_r2) begin
                        if (h_rise) c2_q <= sat_inc(c2_q);
                        if (th_flag && hcount < colp_q) l2_q <= 1'b1;
                        if (th_flag && hcount > colp_q) r2_q <= 1'b1;
                    end
                    if (on_r1 || on_r2) hprev_q <= th_flag;
                    if (on_col) begin
                        if (v_rise) cy_q <= sat_inc(cy_q);
                        vprev_q <= th_flag;
                    end
                end
                StClassify: begin
                    x1 <= c1_q; x2 <= c2_q; y <= cy_q;
                    x1_l <= l1_q; x1_r <= r1_q; x2_l <= l2_q; x2_r <= r2_q;
`ifdef DIGIT_ASPECT_EN
                    digit <= thin_q ? 4'd1 : lookup(cy_q, c1_q, c2_q, l1_q, r1_q, l2_q, r2_q);
`else
                    digit <= lookup(cy_q, c1_q, c2_q, l1_q, r1_q, l2_q, r2_q);
`endif
                    digit_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_digit_crossing_classifier.sv
// Randomized self-checking bench for digit_crossing_classifier; expected results come from an
// image-array model that walks the probe lines directly.
module tb_digit_crossing_classifier;
    localparam int CW    = 12;
    localparam int CNT_W = 4;
    localparam int IMG   = 256;
    localparam int SAT   = 15;

    logic             tft_vclk = 1'b0;
    logic             rst, tft_vs, th_flag, box_valid;
    logic [CW-1:0]    hcount, vcount, box_left, box_right, box_top, box_bottom;
    logic [CNT_W-1:0] x1, x2, y;
    logic             x1_l, x1_r, x2_l, x2_r, digit_valid, busy;
    logic [3:0]       digit;

    digit_crossing_classifier dut (
        .tft_vclk   (tft_vclk),
        .rst        (rst),
        .tft_vs     (tft_vs),
        .th_flag    (th_flag),
        .hcount     (hcount),
        .vcount     (vcount),
        .box_left   (box_left),
        .box_right  (box_right),
        .box_top    (box_top),
        .box_bottom (box_bottom),
        .box_valid  (box_valid),
        .x1         (x1),
        .x2         (x2),
        .y          (y),
        .x1_l       (x1_l),
        .x1_r       (x1_r),
        .x2_l       (x2_l),
        .x2_r       (x2_r),
        .digit      (digit),
        .digit_valid(digit_valid),
        .busy       (busy)
    );

    always #5 tft_vclk = ~tft_vclk;

    int n_checks = 0;
    int n_fail   = 0;
    int dv_seen  = 0;
    int fc       = 0;
    bit img [0:IMG-1][0:IMG-1];

    // expected output state, held between analyses
    int e_x1 = 0, e_x2 = 0, e_y = 0, e_digit = 15;
    bit e_l1 = 0, e_r1 = 0, e_l2 = 0, e_r2 = 0;

    // digit table: counts (y, x1, x2) plus side requirement (0 none, 1 x1_r&x2_l, 2 x1_r&x2_r, 3 x1_l&x2_r)
    int tbl_y  [10] = '{2, 1, 3, 3, 2, 3, 3, 2, 3, 3};
    int tbl_x1 [10] = '{2, 1, 1, 1, 2, 1, 1, 1, 2, 2};
    int tbl_x2 [10] = '{2, 1, 1, 1, 1, 1, 2, 1, 2, 1};
    int tbl_f  [10] = '{0, 0, 1, 2, 0, 3, 0, 0, 0, 0};

    always @(negedge tft_vclk) if (digit_valid) dv_seen++;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge tft_vclk);
        #1;
    endtask

    task automatic vs_pulse();
        hcount = '0; vcount = '0; th_flag = 1'b0;
        tft_vs = 1'b1;
        tick(3);
        tft_vs = 1'b0;
        tick(3);
        fc = (fc + 1) % 4;
    endtask

    task automatic clear_img();
        for (int v = 0; v < IMG; v++)
            for (int h = 0; h < IMG; h++) img[v][h] = 1'b0;
    endtask

    task automatic draw(input int xa, input int xb, input int ya, input int yb);
        for (int v = ya; v <= yb; v++)
            for (int h = xa; h <= xb; h++) img[v][h] = 1'b1;
    endtask

    task automatic stream(input int h0, input int h1, input int v0, input int v1);
        for (int v = v0; v <= v1; v++)
            for (int h = h0; h <= h1; h++) begin
                hcount = CW'(h); vcount = CW'(v); th_flag = img[v][h];
                tick(1);
            end
        hcount = '0; vcount = '0; th_flag = 1'b0;
    endtask

    task automatic model(input int l, input int r, input int t, input int b);
        int p1, p2, pc, n1, n2, nc;
        bit side_ok;
        p1 = t + ((b - t) * 2) / 5;
        p2 = t + ((b - t) * 3) / 5;
        pc = l + (r - l) / 2;
        n1 = 0; n2 = 0; nc = 0;
        e_l1 = 0; e_r1 = 0; e_l2 = 0; e_r2 = 0;
        for (int h = l; h <= r; h++) begin
            if (img[p1][h] && (h == l || !img[p1][h-1])) n1++;
            if (img[p2][h] && (h == l || !img[p2][h-1])) n2++;
            if (img[p1][h] && h < pc) e_l1 = 1;
            if (img[p1][h] && h > pc) e_r1 = 1;
            if (img[p2][h] && h < pc) e_l2 = 1;
            if (img[p2][h] && h > pc) e_r2 = 1;
        end
        for (int v = t; v <= b; v++)
            if (img[v][pc] && (v == t || !img[v-1][pc])) nc++;
        e_x1 = (n1 > SAT) ? SAT : n1;
        e_x2 = (n2 > SAT) ? SAT : n2;
        e_y  = (nc > SAT) ? SAT : nc;
        e_digit = 15;
        for (int d = 9; d >= 0; d--) begin
            case (tbl_f[d])
                1:       side_ok = e_r1 && e_l2;
                2:       side_ok = e_r1 && e_r2;
                3:       side_ok = e_l1 && e_r2;
                default: side_ok = 1;
            endcase
            if (tbl_y[d] == e_y && tbl_x1[d] == e_x1 && tbl_x2[d] == e_x2 && side_ok) e_digit = d;
        end
`ifdef DIGIT_ASPECT_EN
        if ((r - l) * 4 < (b - t)) e_digit = 1;
`endif
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, " x1"}, int'(x1), e_x1);
        check_eq({tag, " x2"}, int'(x2), e_x2);
        check_eq({tag, " y"}, int'(y), e_y);
        check_eq({tag, " flags"}, int'({x1_l, x1_r, x2_l, x2_r}), int'({e_l1, e_r1, e_l2, e_r2}));
        check_eq({tag, " digit"}, int'(digit), e_digit);
    endtask

    task automatic analysis(input int l, input int r, input int t, input int b, input bit valid,
                            input string tag);
        bit exp_start;
        int dv0;
        while ((fc + 1) % 4 != 3) vs_pulse();
        box_left = CW'(l); box_right = CW'(r); box_top = CW'(t); box_bottom = CW'(b);
        box_valid = valid;
        vs_pulse();
        exp_start = valid && (r > l) && (b > t);
        check_eq({tag, " busy"}, int'(busy), int'(exp_start));
        box_left = CW'($urandom); box_right = CW'($urandom);
        box_top = CW'($urandom); box_bottom = CW'($urandom); box_valid = 1'($urandom);
        stream((l > 2) ? l - 2 : 0, (r > l ? r : l) + 2, (t > 2) ? t - 2 : 0, (b > t ? b : t) + 2);
        dv0 = dv_seen;
        vs_pulse();
        tick(2);
        if (exp_start) model(l, r, t, b);
        check_eq({tag, " pulses"}, dv_seen - dv0, int'(exp_start));
        check_eq({tag, " idle"}, int'(busy), 0);
        check_outputs(tag);
    endtask

    initial begin
        int l, t, w, h, dens, dv0;
        rst = 1'b1; tft_vs = 1'b0; th_flag = 1'b0; box_valid = 1'b0;
        hcount = '0; vcount = '0;
        box_left = '0; box_right = '0; box_top = '0; box_bottom = '0;
        tick(3);
        check_eq("reset busy", int'(busy), 0);
        check_eq("reset valid", int'(digit_valid), 0);
        check_outputs("reset");
        rst = 1'b0;
        fc = 0;

        // ring "0"
        clear_img();
        draw(100, 102, 50, 150); draw(138, 140, 50, 150);
        draw(100, 140, 50, 52);  draw(100, 140, 148, 150);
        analysis(100, 140, 50, 150, 1'b1, "zero");
        check_eq("zero spec digit", int'(digit), 0);
        check_eq("zero spec y", int'(y), 2);

        // "5": top-left and bottom-right strokes with three bars
        clear_img();
        draw(100, 140, 50, 54); draw(100, 104, 50, 100); draw(100, 140, 98, 102);
        draw(136, 140, 100, 150); draw(100, 140, 146, 150);
        analysis(100, 140, 50, 150, 1'b1, "five");
        check_eq("five spec digit", int'(digit), 5);
        check_eq("five spec sides", int'({x1_l, x1_r, x2_l, x2_r}), 4'b1001);

        // invalid box on the scan frame: nothing happens, outputs hold
        analysis(100, 140, 50, 150, 1'b0, "novalid");
        check_eq("novalid digit held", int'(digit), 5);

        // degenerate box (zero width) is rejected as well
        analysis(60, 60, 20, 80, 1'b1, "degenerate");

        // 17 stripes on row probe 1 saturate the counter
        clear_img();
        for (int k = 0; k < 17; k++) img[90][100 + 2 * k] = 1'b1;
        analysis(100, 140, 50, 150, 1'b1, "stripes");
        check_eq("stripes spec x1", int'(x1), 15);
        check_eq("stripes spec digit", int'(digit), 15);

        // "8": ring plus middle bar
        clear_img();
        draw(100, 102, 50, 150); draw(138, 140, 50, 150);
        draw(100, 140, 50, 52);  draw(100, 140, 148, 150); draw(100, 140, 98, 102);
        analysis(100, 140, 50, 150, 1'b1, "eight");
        check_eq("eight spec digit", int'(digit), 8);

        // reset in the middle of a scan
        clear_img();
        draw(100, 102, 50, 150); draw(138, 140, 50, 150);
        draw(100, 140, 50, 52);  draw(100, 140, 148, 150);
        while ((fc + 1) % 4 != 3) vs_pulse();
        box_left = 12'd100; box_right = 12'd140; box_top = 12'd50; box_bottom = 12'd150;
        box_valid = 1'b1;
        vs_pulse();
        check_eq("midrst busy before", int'(busy), 1);
        stream(98, 142, 48, 100);
        dv0 = dv_seen;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        fc = 0;
        e_x1 = 0; e_x2 = 0; e_y = 0; e_digit = 15;
        e_l1 = 0; e_r1 = 0; e_l2 = 0; e_r2 = 0;
        check_eq("midrst busy", int'(busy), 0);
        check_outputs("midrst");
        vs_pulse();
        tick(2);
        check_eq("midrst pulses", dv_seen - dv0, 0);
        analysis(100, 140, 50, 150, 1'b1, "after_rst");
        check_eq("after_rst spec digit", int'(digit), 0);

        // thin box, stroke misses the column probe
        clear_img();
        draw(21, 22, 10, 70);
        analysis(20, 28, 10, 70, 1'b1, "thin");
`ifdef DIGIT_ASPECT_EN
        check_eq("thin spec digit", int'(digit), 1);
`else
        check_eq("thin spec digit", int'(digit), 15);
`endif

        // random boxes and noise, including very short boxes where the row probes coincide
        for (int it = 0; it < 10; it++) begin
            l = 4 + $urandom_range(0, 60);
            t = 4 + $urandom_range(0, 60);
            w = $urandom_range(1, 40);
            h = (it < 2) ? $urandom_range(1, 2) : $urandom_range(1, 40);
            dens = $urandom_range(1, 4);
            clear_img();
            for (int v = t - 2; v <= t + h + 2; v++)
                for (int x = l - 2; x <= l + w + 2; x++)
                    img[v][x] = ($urandom_range(0, 7) < dens);
            analysis(l, l + w, t, t + h, 1'b1, $sformatf("rand%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
